// File: rtl/align_1rw_reqarb_pkg.sv
// Shared types and sizing helpers for the 1RW request arbiter and its response FIFO.
package align_1rw_pkg;

    typedef enum logic {
        PRI_RD = 1'b0,
        PRI_WR = 1'b1
    } arb_state_e;

    // The credit counter must hold the value RSPDEPTH itself, hence one extra bit.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/align_1rw_rspfifo.sv
// Read-response FIFO: circular buffer with occupancy count, push and pop allowed together.
module align_1rw_rspfifo #(
    parameter int WIDTH    = 32,
    parameter int RSPDEPTH = 4,
    parameter int BITRSPD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int CNTW = BITRSPD + 1;

    logic [WIDTH-1:0]   r_mem [RSPDEPTH];
    logic [BITRSPD-1:0] r_wptr;
    logic [BITRSPD-1:0] r_rptr;
    logic [CNTW-1:0]    r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Pointers wrap at RSPDEPTH so non-power-of-two depths stay correct.
    function automatic logic [BITRSPD-1:0] ptr_inc(input logic [BITRSPD-1:0] ptr);
        if (ptr == BITRSPD'(RSPDEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + BITRSPD'(1);
        end
    endfunction

    assign o_full    = (r_count == CNTW'(RSPDEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Storage, pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < RSPDEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/align_1rw_reqarb.sv
// Write/read request arbiter in front of a 1RW ramwrap: registered commands,
// credit-limited reads and an in-order response FIFO.
module align_1rw_reqarb
    import align_1rw_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int BITADDR  = 10,
    parameter int RD_LAT   = 2,
    parameter int RSPDEPTH = 4,
    parameter int BITRSPD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [BITADDR-1:0] wr_adr,
    input  logic [WIDTH-1:0]   wr_bw,
    input  logic [WIDTH-1:0]   wr_din,
    output logic               wr_rdy,
    input  logic               rd_req,
    input  logic [BITADDR-1:0] rd_adr,
    output logic               rd_rdy,
    output logic               rsp_vld,
    output logic [WIDTH-1:0]   rsp_dout,
    input  logic               rsp_rdy,
    output logic               write,
    output logic [BITADDR-1:0] wr_adr_o,
    output logic [WIDTH-1:0]   bw,
    output logic [WIDTH-1:0]   din,
    output logic               read,
    output logic [BITADDR-1:0] rd_adr_o,
    input  logic               rd_vld,
    input  logic [WIDTH-1:0]   rd_dout,
    output logic               err_ovf
);

    localparam int CRW = credit_width(RSPDEPTH);
    localparam int DRW = $clog2(RD_LAT + 2);

    arb_state_e         r_state;
    logic [CRW-1:0]     r_credit;
    logic [DRW-1:0]     r_drain;
    logic               r_write;
    logic               r_read;
    logic [BITADDR-1:0] r_wr_adr;
    logic [BITADDR-1:0] r_rd_adr;
    logic [WIDTH-1:0]   r_bw;
    logic [WIDTH-1:0]   r_din;
    logic               r_err_ovf;

    logic w_rd_elig;
    logic w_contend;
    logic w_wr_grant;
    logic w_rd_grant;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_pop;
    logic w_rd_ret;
    logic w_push;
    logic w_ovf;
    logic w_full;
    logic w_empty;

    assign w_rd_elig = (r_credit < CRW'(RSPDEPTH));

    // Grant selection: favoured channel wins contention, a lone requester always wins.
    always_comb begin
        w_contend  = 1'b0;
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (!rst) begin
            w_contend  = 1'b0;
            w_wr_grant = 1'b0;
            w_rd_grant = 1'b0;
        end else if (wr_req && rd_req && w_rd_elig) begin
            w_contend  = 1'b1;
            w_wr_grant = (r_state == PRI_WR);
            w_rd_grant = (r_state == PRI_RD);
        end else if (wr_req) begin
            w_wr_grant = 1'b1;
        end else begin
            w_rd_grant = w_rd_elig;
        end
    end

    assign wr_rdy   = w_wr_grant;
    assign rd_rdy   = w_rd_grant;
    assign w_wr_acc = wr_req && w_wr_grant;
    assign w_rd_acc = rd_req && w_rd_grant;

    assign rsp_vld  = !w_empty;
    assign w_pop    = rsp_vld && rsp_rdy;
    // Returns are ignored while the drain counter runs, so pre-reset reads never land.
    assign w_rd_ret = rd_vld && (r_drain == '0);
    assign w_push   = w_rd_ret && (!w_full || w_pop);
    assign w_ovf    = w_rd_ret && w_full && !w_pop;

    // Priority state: flips to the loser after every contended grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= PRI_RD;
        end else if (w_contend) begin
            r_state <= (r_state == PRI_RD) ? PRI_WR : PRI_RD;
        end else begin
            r_state <= r_state;
        end
    end

    // Registered downstream commands; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_write  <= 1'b0;
            r_read   <= 1'b0;
            r_wr_adr <= '0;
            r_bw     <= '0;
            r_din    <= '0;
            r_rd_adr <= '0;
        end else begin
            r_write <= w_wr_acc;
            r_read  <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_adr <= wr_adr;
                r_bw     <= wr_bw;
                r_din    <= wr_din;
            end
            if (w_rd_acc) begin
                r_rd_adr <= rd_adr;
            end
        end
    end

    // Outstanding-read credits; saturates at zero so forced stray returns cannot wrap it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credit <= '0;
        end else begin
            case ({w_rd_acc, w_pop && (r_credit != '0)})
                2'b10:   r_credit <= r_credit + CRW'(1);
                2'b01:   r_credit <= r_credit - CRW'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Post-reset drain window and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drain   <= DRW'(RD_LAT + 1);
            r_err_ovf <= 1'b0;
        end else begin
            if (r_drain != '0) begin
                r_drain <= r_drain - DRW'(1);
            end else begin
                r_drain <= r_drain;
            end
            r_err_ovf <= r_err_ovf || w_ovf;
        end
    end

    assign write    = r_write;
    assign read     = r_read;
    assign wr_adr_o = r_wr_adr;
    assign bw       = r_bw;
    assign din      = r_din;
    assign rd_adr_o = r_rd_adr;
    assign err_ovf  = r_err_ovf;

    align_1rw_rspfifo #(
        .WIDTH    (WIDTH),
        .RSPDEPTH (RSPDEPTH),
        .BITRSPD  (BITRSPD)
    ) u_rspfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (rd_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (rsp_dout)
    );

endmodule

// File: tb/tb_align_1rw_reqarb.sv
// Directed bench for align_1rw_reqarb with a fixed-latency ramwrap model.
module tb_align_1rw_reqarb;

    localparam int WIDTH    = 32;
    localparam int BITADDR  = 10;
    localparam int RD_LAT   = 2;
    localparam int RSPDEPTH = 4;
    localparam int BITRSPD  = 2;

    logic               clk;
    logic               rst;
    logic               wr_req;
    logic [BITADDR-1:0] wr_adr;
    logic [WIDTH-1:0]   wr_bw;
    logic [WIDTH-1:0]   wr_din;
    logic               wr_rdy;
    logic               rd_req;
    logic [BITADDR-1:0] rd_adr;
    logic               rd_rdy;
    logic               rsp_vld;
    logic [WIDTH-1:0]   rsp_dout;
    logic               rsp_rdy;
    logic               write;
    logic [BITADDR-1:0] wr_adr_o;
    logic [WIDTH-1:0]   bw;
    logic [WIDTH-1:0]   din;
    logic               read;
    logic [BITADDR-1:0] rd_adr_o;
    logic               rd_vld;
    logic [WIDTH-1:0]   rd_dout;
    logic               err_ovf;

    logic               f_vld;
    logic [WIDTH-1:0]   f_dat;
    logic [RD_LAT-1:0]  pipe_vld = '0;
    logic [WIDTH-1:0]   pipe_dat [RD_LAT];
    logic [WIDTH-1:0]   exp_q [4];

    int n_checks = 0;
    int n_err    = 0;

    align_1rw_reqarb #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .RD_LAT(RD_LAT),
        .RSPDEPTH(RSPDEPTH), .BITRSPD(BITRSPD)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_adr(wr_adr), .wr_bw(wr_bw), .wr_din(wr_din), .wr_rdy(wr_rdy),
        .rd_req(rd_req), .rd_adr(rd_adr), .rd_rdy(rd_rdy),
        .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .rsp_rdy(rsp_rdy),
        .write(write), .wr_adr_o(wr_adr_o), .bw(bw), .din(din),
        .read(read), .rd_adr_o(rd_adr_o),
        .rd_vld(rd_vld), .rd_dout(rd_dout), .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_data(input logic [BITADDR-1:0] a);
        return WIDTH'(a) + 32'h0000_0009;
    endfunction

    // Ramwrap model: data for rd_adr_o returns RD_LAT cycles after the read command.
    always @(posedge clk) begin
        pipe_vld[0] <= read;
        pipe_dat[0] <= model_data(rd_adr_o);
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    assign rd_vld  = pipe_vld[RD_LAT-1] | f_vld;
    assign rd_dout = f_vld ? f_dat : pipe_dat[RD_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rsp_rdy = 1'b0;
        wr_adr = '0; wr_bw = '0; wr_din = '0; rd_adr = '0;
        f_vld = 1'b0; f_dat = '0;
        for (int i = 0; i < RD_LAT; i++) pipe_dat[i] = '0;

        // Reset state, with requests asserted to show the ready gating.
        tick(); tick();
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        chk("rst_wr_rdy", wr_rdy, 1'b0);
        chk("rst_rd_rdy", rd_rdy, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_read", read, 1'b0);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_wr_adr_o", wr_adr_o, 10'h000);
        chk("rst_bw", bw, 32'h0);
        chk("rst_din", din, 32'h0);
        chk("rst_rd_adr_o", rd_adr_o, 10'h000);
        tick();
        wr_req = 1'b0; rd_req = 1'b0; rst = 1'b1;
        tick(); tick();

        // Single write: one-cycle command, address/data held afterwards.
        wr_req = 1'b1; wr_adr = 10'h010; wr_din = 32'h0000_CAFE; wr_bw = 32'hFFFF_FFFF;
        #1;
        chk("w_wr_rdy", wr_rdy, 1'b1);
        chk("w_rd_rdy", rd_rdy, 1'b0);
        tick();
        wr_req = 1'b0;
        chk("w_write_t1", write, 1'b1);
        chk("w_adr_t1", wr_adr_o, 10'h010);
        chk("w_din_t1", din, 32'h0000_CAFE);
        chk("w_bw_t1", bw, 32'hFFFF_FFFF);
        chk("w_read_t1", read, 1'b0);
        tick();
        chk("w_write_t2", write, 1'b0);
        chk("w_adr_hold", wr_adr_o, 10'h010);
        chk("w_din_hold", din, 32'h0000_CAFE);

        // Contention from PRI_RD: grants R, W, R, W.
        rsp_rdy = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wr_adr = 10'h020; wr_din = 32'h0000_1111; rd_adr = 10'h005;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb_rd_rdy", rd_rdy, (i % 2) == 0);
            chk("arb_wr_rdy", wr_rdy, (i % 2) != 0);
            tick();
            chk("arb_read", read, (i % 2) == 0);
            chk("arb_write", write, (i % 2) != 0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (8) tick();
        rsp_rdy = 1'b0;

        // Reads to 1,2,3: in-order responses, first at T+2+RD_LAT, head stable under backpressure.
        rd_req = 1'b1; rd_adr = 10'h001;
        #1;
        chk("ord_rd_rdy", rd_rdy, 1'b1);
        tick();
        rd_adr = 10'h002;
        chk("ord_read", read, 1'b1);
        chk("ord_adr1", rd_adr_o, 10'h001);
        tick();
        rd_adr = 10'h003;
        chk("ord_adr2", rd_adr_o, 10'h002);
        tick();
        rd_req = 1'b0;
        chk("ord_adr3", rd_adr_o, 10'h003);
        chk("ord_vld_early", rsp_vld, 1'b0);
        tick();
        chk("ord_vld_first", rsp_vld, 1'b1);
        chk("ord_dout_a", rsp_dout, 32'h0000_000A);
        tick();
        chk("ord_dout_a_hold", rsp_dout, 32'h0000_000A);
        rsp_rdy = 1'b1;
        tick();
        chk("ord_dout_b", rsp_dout, 32'h0000_000B);
        tick();
        chk("ord_dout_c", rsp_dout, 32'h0000_000C);
        tick();
        chk("ord_empty", rsp_vld, 1'b0);
        rsp_rdy = 1'b0;

        // Credit limit: 6 back-to-back reads, only 4 accepted; one pop frees one read.
        for (int i = 0; i < 6; i++) begin
            rd_req = 1'b1; rd_adr = 10'h040 + 10'(i);
            #1;
            chk("crd_rd_rdy", rd_rdy, i < 4);
            tick();
        end
        rd_adr = 10'h046; rsp_rdy = 1'b1;
        #1;
        chk("crd_blocked", rd_rdy, 1'b0);
        chk("crd_vld", rsp_vld, 1'b1);
        chk("crd_head0", rsp_dout, model_data(10'h040));
        tick();
        rsp_rdy = 1'b0;
        #1;
        chk("crd_one_more", rd_rdy, 1'b1);
        chk("crd_head1", rsp_dout, model_data(10'h041));
        tick();
        #1;
        chk("crd_blocked2", rd_rdy, 1'b0);
        rd_req = 1'b0;
        tick(); tick(); tick();

        // Full FIFO: push+pop keeps occupancy; push without pop sets sticky err_ovf.
        chk("ovf_head_full", rsp_dout, model_data(10'h041));
        rsp_rdy = 1'b1; f_vld = 1'b1; f_dat = 32'h0000_F00D;
        tick();
        rsp_rdy = 1'b0; f_dat = 32'h0000_DEAD;
        chk("ovf_head_after", rsp_dout, model_data(10'h042));
        chk("ovf_err_clear", err_ovf, 1'b0);
        tick();
        f_vld = 1'b0;
        chk("ovf_err_set", err_ovf, 1'b1);
        tick();
        chk("ovf_err_sticky", err_ovf, 1'b1);
        exp_q[0] = model_data(10'h042);
        exp_q[1] = model_data(10'h043);
        exp_q[2] = model_data(10'h046);
        exp_q[3] = 32'h0000_F00D;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop_vld", rsp_vld, 1'b1);
            chk("ovf_pop_dout", rsp_dout, exp_q[i]);
            tick();
        end
        chk("ovf_drained", rsp_vld, 1'b0);
        chk("ovf_err_still", err_ovf, 1'b1);
        rsp_rdy = 1'b0;
        tick();

        // Reset with two reads in flight: stale returns dropped, credit cleared.
        rd_req = 1'b1; rd_adr = 10'h060;
        #1;
        chk("inf_rd_rdy", rd_rdy, 1'b1);
        tick();
        rd_adr = 10'h061;
        tick();
        rd_req = 1'b0; rst = 1'b0;
        #1;
        chk("inf_rst_rd_rdy", rd_rdy, 1'b0);
        chk("inf_rst_wr_rdy", wr_rdy, 1'b0);
        tick();
        rst = 1'b1; rd_req = 1'b1; rd_adr = 10'h070;
        #1;
        chk("inf_rel_rd_rdy", rd_rdy, 1'b1);
        chk("inf_rel_err", err_ovf, 1'b0);
        chk("inf_rel_vld", rsp_vld, 1'b0);
        chk("inf_rel_read", read, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            rd_adr = 10'h070 + 10'(k);
            #1;
            chk("inf_rd_rdy", rd_rdy, k < 4);
            chk("inf_rsp_vld", rsp_vld, k == 4);
        end
        rd_req = 1'b0;
        chk("inf_first_new", rsp_dout, model_data(10'h070));
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
